// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared constants for the FPU datapath and its arbiters: default float
// format, multiplier pipeline depth and a helper for requester-id width.
// Imported by floating_point_multiply users and by the FPU arbiters.
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int FPU_FRAC_WIDTH  = 24;  // fraction incl. hidden bit
  localparam int FPU_EXP_WIDTH   = 8;
  localparam int FPU_DATA_WIDTH  = FPU_FRAC_WIDTH + FPU_EXP_WIDTH;
  localparam int FPU_MUL_LATENCY = 10;  // multiplier validIn -> validOut

  // Width of a requester id; never narrower than one bit so that a
  // single-requester configuration still has a legal vector.
  function automatic int fpu_id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_rr_arbiter
// Purely combinational round-robin picker. Searches req_i starting at ptr_i
// and wrapping around; the first set request wins.
// Ports:
//   req_i        [NUM_REQ]  request vector
//   ptr_i        [IDW]      highest-priority index this cycle
//   gnt_o        [NUM_REQ]  one-hot-or-zero grant
//   gnt_id_o     [IDW]      index of the winner (0 when none)
//   gnt_valid_o  1          a winner exists
// -----------------------------------------------------------------------------
module fpu_rr_arbiter
  import fpu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = fpu_id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic               gnt_valid_o
);

  // Two passes: indices at/above the pointer first, then the wrapped part.
  always_comb begin
    logic found;
    logic hit;
    found       = 1'b0;
    hit         = 1'b0;
    gnt_o       = '0;
    gnt_id_o    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit      = !found && (i >= int'(ptr_i)) && req_i[i];
      gnt_o[i] = gnt_o[i] | hit;
      gnt_id_o = hit ? IDW'(i) : gnt_id_o;
      found    = found | hit;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      hit      = !found && (i < int'(ptr_i)) && req_i[i];
      gnt_o[i] = gnt_o[i] | hit;
      gnt_id_o = hit ? IDW'(i) : gnt_id_o;
      found    = found | hit;
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_mul_arbiter
// Shares one pipelined floating-point multiplier among NUM_REQ requesters.
// A round-robin grant admits at most one operand pair per cycle; a tag pipe
// running beside the multiplier remembers who issued each operation so the
// result can be steered back. Each requester is capped at MAX_OUTSTANDING
// operations in flight.
// Ports:
//   clkIn, rstIn            clock, asynchronous active-high reset
//   reqValidIn/reqReadyOut  per-requester handshake (ready is one-hot-or-zero)
//   reqDataAIn/reqDataBIn   packed operands, requester i at [i*DW +: DW]
//   respValidOut            one-cycle result strobe to the owning requester
//   respDataOut             result, shared by all requesters, held between strobes
//   mulDataAOut/BOut/ValidOut  issue side of the external multiplier
//   mulDataIn/mulValidIn    result side of the external multiplier
//   busyOut                 some requester has an operation in flight
//   errorOut                sticky: multiplier valid disagreed with tag pipe
// -----------------------------------------------------------------------------
module fpu_mul_arbiter
  import fpu_pkg::*;
#(
  parameter  int FRAC_WIDTH      = FPU_FRAC_WIDTH,
  parameter  int EXP_WIDTH       = FPU_EXP_WIDTH,
  parameter  int NUM_REQ         = 2,
  parameter  int MUL_LATENCY     = FPU_MUL_LATENCY,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int DATA_WIDTH      = FRAC_WIDTH + EXP_WIDTH
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic [NUM_REQ-1:0]            reqValidIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataAIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataBIn,
  output logic [NUM_REQ-1:0]            reqReadyOut,
  output logic [NUM_REQ-1:0]            respValidOut,
  output logic [DATA_WIDTH-1:0]         respDataOut,
  output logic [DATA_WIDTH-1:0]         mulDataAOut,
  output logic [DATA_WIDTH-1:0]         mulDataBOut,
  output logic                          mulValidOut,
  input  logic [DATA_WIDTH-1:0]         mulDataIn,
  input  logic                          mulValidIn,
  output logic                          busyOut,
  output logic                          errorOut
);

  localparam int IDW = fpu_id_width(NUM_REQ);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REQ-1:0]    elig_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [IDW-1:0]        gnt_id_s;
  logic                  gnt_valid_s;
  logic [DATA_WIDTH-1:0] mux_a_s;
  logic [DATA_WIDTH-1:0] mux_b_s;

  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                  mul_valid_q;
  logic [DATA_WIDTH-1:0] mul_a_q, mul_b_q;
  // Stage 0 is loaded together with mulValidOut; the remaining MUL_LATENCY
  // stages mirror the multiplier's own pipe, so stage MUL_LATENCY lines up
  // with mulValidIn.
  logic [MUL_LATENCY:0]  tag_valid_q;
  logic [IDW-1:0]        tag_id_q [0:MUL_LATENCY];
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [CW-1:0]         cnt_q [NUM_REQ];
  logic [CW-1:0]         cnt_d [NUM_REQ];
  logic                  busy_q, busy_d;
  logic                  error_q;

  logic                  tag_last_valid_s;
  logic [IDW-1:0]        tag_last_id_s;
  logic                  resp_fire_s;
  logic                  mismatch_s;

  // Eligibility looks only at the registered count: a slot freed this cycle
  // is not reusable until the next one.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = reqValidIn[i] && (cnt_q[i] < CW'(MAX_OUTSTANDING));
    end
  end

  fpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i       (elig_s),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt_s),
    .gnt_id_o    (gnt_id_s),
    .gnt_valid_o (gnt_valid_s)
  );

  // One-hot AND-OR operand mux driven by the grant vector.
  always_comb begin
    mux_a_s = '0;
    mux_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mux_a_s = mux_a_s | (reqDataAIn[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_s[i]}});
      mux_b_s = mux_b_s | (reqDataBIn[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_s[i]}});
    end
  end

  assign tag_last_valid_s = tag_valid_q[MUL_LATENCY];
  assign tag_last_id_s    = tag_id_q[MUL_LATENCY];
  assign resp_fire_s      = mulValidIn && tag_last_valid_s;
  assign mismatch_s       = mulValidIn != tag_last_valid_s;

  // Next round-robin pointer, per-requester counters, response strobe, busy.
  always_comb begin
    logic inc_v;
    logic dec_v;
    inc_v        = 1'b0;
    dec_v        = 1'b0;
    busy_d       = 1'b0;
    resp_valid_d = '0;
    if (gnt_valid_s) begin
      if (int'(gnt_id_s) == NUM_REQ - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_id_s + IDW'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_d[i] = resp_fire_s && (tag_last_id_s == IDW'(i));
      inc_v = gnt_s[i];
      dec_v = resp_valid_q[i];
      if (inc_v && !dec_v) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec_v && !inc_v) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      busy_d = busy_d | (cnt_d[i] != '0);
    end
  end

  // Issue stage and tag pipe: shifts every cycle, never stalls.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      rr_ptr_q    <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_valid_q <= '0;
      for (int k = 0; k <= MUL_LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mul_valid_q <= gnt_valid_s;
      if (gnt_valid_s) begin
        mul_a_q <= mux_a_s;
        mul_b_q <= mux_b_s;
      end
      tag_valid_q <= {tag_valid_q[MUL_LATENCY-1:0], gnt_valid_s};
      tag_id_q[0] <= gnt_id_s;
      for (int k = 1; k <= MUL_LATENCY; k++) begin
        tag_id_q[k] <= tag_id_q[k-1];
      end
    end
  end

  // Return path, outstanding counters, busy and the sticky error flag.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      resp_valid_q <= resp_valid_d;
      if (resp_fire_s) begin
        resp_data_q <= mulDataIn;
      end
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      if (mismatch_s) begin
        error_q <= 1'b1;
      end
    end
  end

  assign reqReadyOut  = gnt_s;
  assign respValidOut = resp_valid_q;
  assign respDataOut  = resp_data_q;
  assign mulDataAOut  = mul_a_q;
  assign mulDataBOut  = mul_b_q;
  assign mulValidOut  = mul_valid_q;
  assign busyOut      = busy_q;
  assign errorOut     = error_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_mul_arbiter
// Directed bench for fpu_mul_arbiter with a behavioural 10-stage float32
// multiplier standing in for floating_point_multiply.
// -----------------------------------------------------------------------------
module tb_fpu_mul_arbiter;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic [1:0]  reqValidIn = 2'b00;
  logic [63:0] reqDataAIn = 64'h0;
  logic [63:0] reqDataBIn = 64'h0;
  logic [1:0]  reqReadyOut;
  logic [1:0]  respValidOut;
  logic [31:0] respDataOut;
  logic [31:0] mulDataAOut;
  logic [31:0] mulDataBOut;
  logic        mulValidOut;
  logic [31:0] mulDataIn;
  logic        mulValidIn;
  logic        busyOut;
  logic        errorOut;
  logic        force_v = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clkIn = ~clkIn;

  fpu_mul_arbiter dut (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .reqValidIn   (reqValidIn),
    .reqDataAIn   (reqDataAIn),
    .reqDataBIn   (reqDataBIn),
    .reqReadyOut  (reqReadyOut),
    .respValidOut (respValidOut),
    .respDataOut  (respDataOut),
    .mulDataAOut  (mulDataAOut),
    .mulDataBOut  (mulDataBOut),
    .mulValidOut  (mulValidOut),
    .mulDataIn    (mulDataIn),
    .mulValidIn   (mulValidIn),
    .busyOut      (busyOut),
    .errorOut     (errorOut)
  );

  // Behavioural float32 multiply, round-to-nearest-even, denormals as zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [47:0] p;
    logic [23:0] m;
    logic [24:0] mr;
    logic        g, st;
    int          e;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    if ((ea == 8'hFF && a[22:0] != 23'h0) || (eb == 8'hFF && b[22:0] != 23'h0)) return 32'h7FC00000;
    if ((ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00)) return 32'h7FC00000;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'h0};
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    mr = {1'b0, m} + {24'h0, (g && (st || m[0]))};
    if (mr[24]) begin
      m = mr[24:1]; e = e + 1;
    end else begin
      m = mr[23:0];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  // Multiplier model: validOut appears 10 cycles after validIn.
  logic [9:0]  mp_v;
  logic [31:0] mp_d [0:9];
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      mp_v <= '0;
    end else begin
      mp_v    <= {mp_v[8:0], mulValidOut};
      mp_d[0] <= fmul(mulDataAOut, mulDataBOut);
      for (int k = 1; k < 10; k++) mp_d[k] <= mp_d[k-1];
    end
  end
  assign mulValidIn = mp_v[9] | force_v;
  assign mulDataIn  = mp_d[9];

  logic [31:0] ta [0:1][0:3] = '{'{32'h40000000, 32'h3FC00000, 32'h40800000, 32'hBF800000},
                                 '{32'h40400000, 32'h3F000000, 32'h40000000, 32'h3F800000}};
  logic [31:0] tb [0:1][0:3] = '{'{32'h40400000, 32'h40000000, 32'h3F000000, 32'h40000000},
                                 '{32'h40400000, 32'h3F000000, 32'h40000000, 32'h3F800000}};
  logic [31:0] tp [0:1][0:3] = '{'{32'h40C00000, 32'h40400000, 32'h40000000, 32'hC0000000},
                                 '{32'h41100000, 32'h3E800000, 32'h40800000, 32'h3F800000}};

  task automatic do_reset();
    reqValidIn = 2'b00;
    force_v    = 1'b0;
    @(negedge clkIn);
    rstIn = 1'b1;
    @(negedge clkIn);
    rstIn = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clkIn);
    checks++;
    if ({reqReadyOut, respValidOut, mulValidOut, busyOut, errorOut} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {reqReadyOut, respValidOut, mulValidOut, busyOut, errorOut});
    end
    checks++;
    if ({respDataOut, mulDataAOut, mulDataBOut} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {respDataOut, mulDataAOut, mulDataBOut});
    end
    rstIn = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clkIn);
      if (c == 0) begin
        reqValidIn = 2'b01; reqDataAIn[31:0] = 32'h40000000; reqDataBIn[31:0] = 32'h40400000;
        #1;
        checks++;
        if (reqReadyOut !== 2'b01) begin
          errors++; $display("FAIL single_ready: got %b expected 01", reqReadyOut);
        end
      end else begin
        reqValidIn = 2'b00;
        if (c == 1) begin
          checks++;
          if (busyOut !== 1'b1) begin errors++; $display("FAIL single_busy_hi: got %b expected 1", busyOut); end
        end
        if (c <= 11 || c == 13) begin
          checks++;
          if (respValidOut !== 2'b00) begin errors++; $display("FAIL single_no_resp c=%0d: got %b expected 00", c, respValidOut); end
        end
        if (c == 12) begin
          checks++;
          if (respValidOut !== 2'b01 || respDataOut !== 32'h40C00000) begin
            errors++; $display("FAIL single_resp: got %b/%h expected 01/40c00000", respValidOut, respDataOut);
          end
        end
        if (c == 13) begin
          checks++;
          if (busyOut !== 1'b0) begin errors++; $display("FAIL single_busy_lo: got %b expected 0", busyOut); end
        end
      end
    end
  endtask

  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    logic [1:0] exp_g;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      @(negedge clkIn);
      if (c >= 12 && c < 20) begin
        exp_g = ((c - 12) % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (respValidOut !== exp_g || respDataOut !== tp[(c-12)%2][(c-12)/2]) begin
          errors++; $display("FAIL cont_resp c=%0d: got %b/%h expected %b/%h", c, respValidOut, respDataOut, exp_g, tp[(c-12)%2][(c-12)/2]);
        end
      end else begin
        checks++;
        if (respValidOut !== 2'b00) begin errors++; $display("FAIL cont_no_resp c=%0d: got %b expected 00", c, respValidOut); end
      end
      if (c < 8) begin
        reqValidIn = {n1 < 4, n0 < 4};
        reqDataAIn = {ta[1][(n1 < 4) ? n1 : 3], ta[0][(n0 < 4) ? n0 : 3]};
        reqDataBIn = {tb[1][(n1 < 4) ? n1 : 3], tb[0][(n0 < 4) ? n0 : 3]};
        #1;
        exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (reqReadyOut !== exp_g) begin errors++; $display("FAIL cont_grant c=%0d: got %b expected %b", c, reqReadyOut, exp_g); end
        n0 = n0 + int'(reqValidIn[0] & reqReadyOut[0]);
        n1 = n1 + int'(reqValidIn[1] & reqReadyOut[1]);
      end else begin
        reqValidIn = 2'b00;
      end
    end
  endtask

  task automatic test_cap();
    int acc = 0;
    int rsp = 0;
    logic [1:0] exp_r;
    do_reset();
    reqDataAIn[31:0] = 32'h40000000;
    reqDataBIn[31:0] = 32'h40400000;
    for (int c = 0; c < 30; c++) begin
      @(negedge clkIn);
      if (respValidOut[0]) begin
        rsp++;
        checks++;
        if (respDataOut !== 32'h40C00000) begin errors++; $display("FAIL cap_data c=%0d: got %h expected 40c00000", c, respDataOut); end
      end
      reqValidIn = 2'b01;
      #1;
      exp_r = {1'b0, (c % 13) < 4};
      checks++;
      if (reqReadyOut !== exp_r) begin errors++; $display("FAIL cap_ready c=%0d: got %b expected %b", c, reqReadyOut, exp_r); end
      acc = acc + int'(reqReadyOut[0]);
      checks++;
      if (acc - rsp > 4) begin errors++; $display("FAIL cap_outstanding c=%0d: got %0d expected <=4", c, acc - rsp); end
    end
    reqValidIn = 2'b00;
  endtask

  task automatic test_specials();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      @(negedge clkIn);
      if (c == 0) begin
        reqValidIn = 2'b11;
        reqDataAIn = {32'h7E967699, 32'h7F800000};
        reqDataBIn = {32'h7E967699, 32'h00000000};
        #1;
        checks++;
        if (reqReadyOut !== 2'b01) begin errors++; $display("FAIL spec_ready0: got %b expected 01", reqReadyOut); end
      end else if (c == 1) begin
        reqValidIn = 2'b10;
        #1;
        checks++;
        if (reqReadyOut !== 2'b10) begin errors++; $display("FAIL spec_ready1: got %b expected 10", reqReadyOut); end
      end else begin
        reqValidIn = 2'b00;
      end
      if (c == 12) begin
        checks++;
        if (respValidOut !== 2'b01 || respDataOut !== 32'h7FC00000) begin
          errors++; $display("FAIL spec_inf_zero: got %b/%h expected 01/7fc00000", respValidOut, respDataOut);
        end
      end
      if (c == 13) begin
        checks++;
        if (respValidOut !== 2'b10 || respDataOut !== 32'h7F800000) begin
          errors++; $display("FAIL spec_overflow: got %b/%h expected 10/7f800000", respValidOut, respDataOut);
        end
      end
    end
  endtask

  task automatic test_error();
    int stray = 0;
    do_reset();
    @(negedge clkIn);
    checks++;
    if (errorOut !== 1'b0) begin errors++; $display("FAIL err_pre: got %b expected 0", errorOut); end
    force_v = 1'b1;
    @(negedge clkIn);
    force_v = 1'b0;
    checks++;
    if (errorOut !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", errorOut); end
    for (int c = 0; c < 6; c++) begin
      if (respValidOut !== 2'b00) stray++;
      @(negedge clkIn);
    end
    checks++;
    if (errorOut !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", errorOut); end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL err_no_resp: got %0d strobes expected 0", stray); end
    checks++;
    if (busyOut !== 1'b0) begin errors++; $display("FAIL err_busy: got %b expected 0", busyOut); end
  endtask

  task automatic test_reset_midflight();
    int stray = 0;
    do_reset();
    reqDataAIn[31:0] = 32'h40000000;
    reqDataBIn[31:0] = 32'h40400000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clkIn);
      reqValidIn = (c < 3) ? 2'b01 : 2'b00;
    end
    checks++;
    if (busyOut !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b expected 1", busyOut); end
    #2 rstIn = 1'b1;
    #1;
    checks++;
    if ({respValidOut, mulValidOut, busyOut, errorOut, reqReadyOut} !== 7'b0) begin
      errors++; $display("FAIL mid_async: got %b expected 0000000", {respValidOut, mulValidOut, busyOut, errorOut, reqReadyOut});
    end
    #1 rstIn = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clkIn);
      if (respValidOut !== 2'b00) stray++;
    end
    checks++;
    if (stray != 0 || busyOut !== 1'b0) begin
      errors++; $display("FAIL mid_quiet: got %0d strobes busy=%b expected 0/0", stray, busyOut);
    end
    for (int c = 0; c < 13; c++) begin
      @(negedge clkIn);
      reqValidIn = (c == 0) ? 2'b01 : 2'b00;
      if (c == 12) begin
        checks++;
        if (respValidOut !== 2'b01 || respDataOut !== 32'h40C00000) begin
          errors++; $display("FAIL mid_new_op: got %b/%h expected 01/40c00000", respValidOut, respDataOut);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_cap();
    test_specials();
    test_error();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
